// File: rtl/gray_pkg.sv
// Shared types and Gray-code helpers for the Gray count receive path.
// Functions work on a fixed wide vector; callers zero-extend and truncate.
package gray_pkg;

  localparam int GW = 32;
  localparam int PW = 6;

  typedef enum logic [1:0] {
    WARMUP,
    PRIME,
    TRACK
  } gsd_state_t;

  function automatic logic [GW-1:0] gray2bin(
    input logic [GW-1:0] g
  );
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GW-1:0] bin2gray(
    input logic [GW-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] popcount(
    input logic [GW-1:0] v
  );
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < GW; i++) begin
      c = c + PW'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a bus that changes at most one bit at a time.
// Reusable on any CDC path that carries Gray-coded data.
module sync_chain #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_sync [SYNC_STAGES];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/gray_sync_decoder.sv
// Receive side of a Gray counter CDC: synchronize, decode to binary,
// report per-cycle progress and flag illegal multi-bit Gray changes.
module gray_sync_decoder #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [N-1:0]     i_gray_async,
  input  logic             i_clear,
  output logic             o_valid,
  output logic [N-1:0]     o_binary,
  output logic [N-1:0]     o_delta,
  output logic             o_step,
  output logic             o_glitch,
  output logic [ERR_W-1:0] o_err_count
);

  import gray_pkg::*;

  localparam int CW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] WU_LAST = CW'(SYNC_STAGES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  gsd_state_t r_state;
  gsd_state_t w_state_nx;

  logic [CW-1:0]    r_wu_cnt;
  logic [N-1:0]     r_g_prev;
  logic             r_valid;
  logic [N-1:0]     r_binary;
  logic [N-1:0]     r_delta;
  logic             r_step;
  logic             r_glitch;
  logic [ERR_W-1:0] r_err;

  logic [CW-1:0]    w_wu_cnt_nx;
  logic [N-1:0]     w_g_prev_nx;
  logic             w_valid_nx;
  logic [N-1:0]     w_binary_nx;
  logic [N-1:0]     w_delta_nx;
  logic             w_step_nx;
  logic             w_glitch_nx;
  logic [ERR_W-1:0] w_err_nx;

  logic [N-1:0] w_g_cur;
  logic [N-1:0] w_bin_cur;
  logic [N-1:0] w_delta;
  logic         w_glitch;

  sync_chain #(
    .N          (N),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_d      (i_gray_async),
    .o_q      (w_g_cur)
  );

  assign w_bin_cur = N'(gray2bin(GW'(w_g_cur)));
  assign w_delta   = w_bin_cur - r_binary;
  assign w_glitch  =
    popcount(GW'(w_g_cur ^ r_g_prev)) > PW'(1);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= WARMUP;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      WARMUP: begin
        if (r_wu_cnt == WU_LAST) begin
          w_state_nx = PRIME;
        end
      end
      PRIME:   w_state_nx = TRACK;
      TRACK:   w_state_nx = TRACK;
      default: w_state_nx = WARMUP;
    endcase
  end

  // Clear is applied before a same-cycle glitch so the new event survives.
  always_comb begin
    w_wu_cnt_nx = r_wu_cnt;
    w_g_prev_nx = r_g_prev;
    w_valid_nx  = r_valid;
    w_binary_nx = r_binary;
    w_delta_nx  = r_delta;
    w_step_nx   = 1'b0;
    w_glitch_nx = r_glitch;
    w_err_nx    = r_err;
    unique case (r_state)
      WARMUP: begin
        w_wu_cnt_nx = r_wu_cnt + CW'(1);
      end
      PRIME: begin
        w_valid_nx  = 1'b1;
        w_binary_nx = w_bin_cur;
        w_delta_nx  = '0;
        w_g_prev_nx = w_g_cur;
      end
      TRACK: begin
        w_binary_nx = w_bin_cur;
        w_delta_nx  = w_delta;
        w_step_nx   = (w_delta == N'(1));
        w_g_prev_nx = w_g_cur;
        if (i_clear) begin
          w_glitch_nx = 1'b0;
          w_err_nx    = '0;
        end
        if (w_glitch) begin
          w_glitch_nx = 1'b1;
          if (w_err_nx != ERR_MAX) begin
            w_err_nx = w_err_nx + ERR_W'(1);
          end
        end
      end
      default: begin
        w_wu_cnt_nx = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wu_cnt <= '0;
      r_g_prev <= '0;
      r_valid  <= 1'b0;
      r_binary <= '0;
      r_delta  <= '0;
      r_step   <= 1'b0;
      r_glitch <= 1'b0;
      r_err    <= '0;
    end else begin
      r_wu_cnt <= w_wu_cnt_nx;
      r_g_prev <= w_g_prev_nx;
      r_valid  <= w_valid_nx;
      r_binary <= w_binary_nx;
      r_delta  <= w_delta_nx;
      r_step   <= w_step_nx;
      r_glitch <= w_glitch_nx;
      r_err    <= w_err_nx;
    end
  end

  assign o_valid     = r_valid;
  assign o_binary    = r_binary;
  assign o_delta     = r_delta;
  assign o_step      = r_step;
  assign o_glitch    = r_glitch;
  assign o_err_count = r_err;

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Bench for gray_sync_decoder: vector table, directed corner cases and
// random Gray traffic against a delay-line reference model.
module tb_gray_sync_decoder;

  localparam int N    = 4;
  localparam int S    = 2;
  localparam int EW   = 8;
  localparam int EMAX = (1 << EW) - 1;
  localparam int MOD  = 1 << N;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr   = 1'b0;
  logic [N-1:0]  gray  = '0;
  logic          valid;
  logic [N-1:0]  binary;
  logic [N-1:0]  delta;
  logic          step;
  logic          glitch;
  logic [EW-1:0] errc;

  gray_sync_decoder #(
    .N          (N),
    .SYNC_STAGES(S),
    .ERR_W      (EW)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_gray_async(gray),
    .i_clear     (clr),
    .o_valid     (valid),
    .o_binary    (binary),
    .o_delta     (delta),
    .o_step      (step),
    .o_glitch    (glitch),
    .o_err_count (errc)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: outputs at edge e come from the input seen at edge e-S.
  int m_e;
  int hist[$];
  int m_valid, m_bin, m_delta, m_step, m_glitch, m_err;

  typedef struct {
    int g; int c;
    int v; int b; int d; int s; int gl; int e;
  } vec_t;

  localparam int NV = 13;
  vec_t vt[NV];

  function automatic int g2b(input int g);
    for (int v = 0; v < MOD; v++) begin
      if ((v ^ (v >> 1)) == g) return v;
    end
    return -1;
  endfunction

  function automatic int b2g(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic void chk(input string nm, input int act,
                              input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_e = 0;
    hist.delete();
    m_valid = 0; m_bin = 0; m_delta = 0;
    m_step = 0; m_glitch = 0; m_err = 0;
  endfunction

  function automatic void model_edge(input int g, input int c);
    int cur, prv, nb;
    hist.push_back(g);
    m_e++;
    m_step = 0;
    if (m_e == S + 1) begin
      cur = hist[m_e-S-1];
      m_valid = 1;
      m_bin = g2b(cur);
      m_delta = 0;
    end else if (m_e > S + 1) begin
      cur = hist[m_e-S-1];
      prv = hist[m_e-S-2];
      nb = g2b(cur);
      m_delta = (nb - m_bin + MOD) % MOD;
      m_step = (m_delta == 1) ? 1 : 0;
      m_bin = nb;
      if (c != 0) begin
        m_glitch = 0;
        m_err = 0;
      end
      if ($countones(cur ^ prv) > 1) begin
        m_glitch = 1;
        if (m_err < EMAX) m_err++;
      end
    end
  endfunction

  function automatic void cmp_model(input string tag);
    chk({tag, ".valid"},  int'(valid),  m_valid);
    chk({tag, ".binary"}, int'(binary), m_bin);
    chk({tag, ".delta"},  int'(delta),  m_delta);
    chk({tag, ".step"},   int'(step),   m_step);
    chk({tag, ".glitch"}, int'(glitch), m_glitch);
    chk({tag, ".errcnt"}, int'(errc),   m_err);
  endfunction

  task automatic tick(input int g, input int c, input string tag);
    gray = N'(g);
    clr  = (c != 0);
    @(posedge clk);
    #1;
    model_edge(g, c);
    cmp_model(tag);
  endtask

  // Called at posedge+1; reset lands mid-cycle and must act at once.
  task automatic do_reset(input string tag);
    #1;
    rst_n = 1'b0;
    clr   = 1'b0;
    #1;
    model_reset();
    cmp_model({tag, ".async"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int g, c, rg, b, r;

    vt[0]  = '{g:0, c:0, v:1, b:0, d:0,  s:0, gl:0, e:0};
    vt[1]  = '{g:1, c:0, v:1, b:1, d:1,  s:1, gl:0, e:0};
    vt[2]  = '{g:3, c:0, v:1, b:2, d:1,  s:1, gl:0, e:0};
    vt[3]  = '{g:2, c:0, v:1, b:3, d:1,  s:1, gl:0, e:0};
    vt[4]  = '{g:2, c:0, v:1, b:3, d:0,  s:0, gl:0, e:0};
    vt[5]  = '{g:3, c:0, v:1, b:2, d:15, s:0, gl:0, e:0};
    vt[6]  = '{g:2, c:0, v:1, b:3, d:1,  s:1, gl:0, e:0};
    vt[7]  = '{g:6, c:0, v:1, b:4, d:1,  s:1, gl:0, e:0};
    vt[8]  = '{g:1, c:0, v:1, b:1, d:13, s:0, gl:1, e:1};
    vt[9]  = '{g:6, c:1, v:1, b:4, d:3,  s:0, gl:1, e:1};
    vt[10] = '{g:6, c:1, v:1, b:4, d:0,  s:0, gl:0, e:0};
    vt[11] = '{g:7, c:0, v:1, b:5, d:1,  s:1, gl:0, e:0};
    vt[12] = '{g:5, c:0, v:1, b:6, d:1,  s:1, gl:0, e:0};

    model_reset();
    @(posedge clk);
    #1;

    // Prime from a held value
    do_reset("t1");
    tick(6, 0, "t1");
    chk("t1.valid_e1", int'(valid), 0);
    tick(6, 0, "t1");
    chk("t1.valid_e2", int'(valid), 0);
    tick(6, 0, "t1");
    chk("t1.valid_e3", int'(valid), 1);
    chk("t1.binary_e3", int'(binary), 4);
    chk("t1.delta_e3", int'(delta), 0);
    chk("t1.step_e3", int'(step), 0);

    // Vector table; results appear S edges after the input
    do_reset("tbl");
    for (int t = 0; t < NV + S; t++) begin
      g = (t < NV) ? vt[t].g : vt[NV-1].g;
      c = (t >= S) ? vt[t-S].c : 0;
      tick(g, c, "tbl");
      if (t >= S) begin
        chk($sformatf("tbl[%0d].valid", t-S), int'(valid), vt[t-S].v);
        chk($sformatf("tbl[%0d].binary", t-S), int'(binary), vt[t-S].b);
        chk($sformatf("tbl[%0d].delta", t-S), int'(delta), vt[t-S].d);
        chk($sformatf("tbl[%0d].step", t-S), int'(step), vt[t-S].s);
        chk($sformatf("tbl[%0d].glitch", t-S), int'(glitch), vt[t-S].gl);
        chk($sformatf("tbl[%0d].errcnt", t-S), int'(errc), vt[t-S].e);
      end else begin
        chk("tbl.valid_warmup", int'(valid), 0);
      end
    end

    // Reset mid-track, then a slowly advancing source
    do_reset("mrst");
    chk("mrst.binary0", int'(binary), 0);
    chk("mrst.valid0", int'(valid), 0);
    b = 5;
    for (int t = 0; t < 24; t++) begin
      if (t % 3 == 0) b = (b + 1) % MOD;
      tick(b2g(b), 0, "mrst");
      if (t < S) chk("mrst.valid_warm", int'(valid), 0);
      if (t == S) begin
        chk("mrst.prime_bin", int'(binary), 6);
        chk("mrst.prime_step", int'(step), 0);
        chk("mrst.prime_glitch", int'(glitch), 0);
      end
    end

    // Wrap 15 -> 0
    do_reset("wrap");
    for (int t = 0; t < 3; t++) tick(8, 0, "wrap");
    chk("wrap.bin15", int'(binary), 15);
    for (int t = 0; t < 3; t++) tick(0, 0, "wrap");
    chk("wrap.bin0", int'(binary), 0);
    chk("wrap.delta", int'(delta), 1);
    chk("wrap.step", int'(step), 1);
    chk("wrap.glitch", int'(glitch), 0);
    tick(0, 0, "wrap");
    chk("wrap.step_once", int'(step), 0);

    // Saturating error counter
    for (int i = 0; i < 302; i++) tick((i % 2 != 0) ? 6 : 1, 0, "sat");
    tick(6, 0, "sat");
    tick(6, 0, "sat");
    chk("sat.errcnt", int'(errc), EMAX);
    chk("sat.glitch", int'(glitch), 1);
    tick(6, 1, "sat");
    chk("sat.clr_err", int'(errc), 0);
    chk("sat.clr_glitch", int'(glitch), 0);

    // Random Gray traffic
    do_reset("rnd");
    rg = 0;
    for (int t = 0; t < 400; t++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60) rg = b2g((g2b(rg) + 1) % MOD);
      else if (r < 70) rg = rg;
      else if (r < 80) rg = b2g((g2b(rg) + MOD - 1) % MOD);
      else rg = int'($urandom_range(0, MOD - 1));
      c = ($urandom_range(0, 19) == 0) ? 1 : 0;
      tick(rg, c, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
